// File: rtl/drum_voice_sched.sv
// Multi-voice drum sample scheduler: on each sample tick, reads every active voice
// from a shared single-port sample RAM and outputs their saturated sum.
// Optional macro DRUM_VOICE_SCHED_GAIN_EN adds a per-voice 2-bit right-shift gain input.
module drum_voice_sched #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_LEN = 6778
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] trig,
`ifdef DRUM_VOICE_SCHED_GAIN_EN
    input  logic [2*NUM_VOICES-1:0] gain,
`endif
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic [DATA_W-1:0]     sample_out,
    output logic                  sample_valid,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  overrun
);

    localparam int ACC_W = DATA_W + $clog2(NUM_VOICES);
    localparam int V_W   = $clog2(NUM_VOICES + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLE_LEN - 1);

    typedef enum logic [1:0] {IDLE, SEL, RD, OUT} state_t;

    state_t                    state_q, state_d;
    logic [V_W-1:0]            v_q, v_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]         ptr_q [NUM_VOICES];
    logic [ADDR_W-1:0]         ptr_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]     active_q, active_d;
    logic [NUM_VOICES-1:0]     pending_q, pending_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic signed [DATA_W-1:0]  out_q, out_d;
    logic                      valid_q, valid_d;
    logic                      overrun_q, overrun_d;

    logic                      cur_active;
    logic [ADDR_W-1:0]         cur_ptr;
    logic signed [DATA_W-1:0]  rd_scaled;
    logic signed [ACC_W-1:0]   rd_ext;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = ACC_W'($signed({1'b0, {(DATA_W-1){1'b1}}}));
        lo = ACC_W'($signed({1'b1, {(DATA_W-1){1'b0}}}));
        if (a > hi)      return hi[DATA_W-1:0];
        else if (a < lo) return lo[DATA_W-1:0];
        else             return a[DATA_W-1:0];
    endfunction

`ifdef DRUM_VOICE_SCHED_GAIN_EN
    logic [1:0] cur_gain;
`endif

    // Per-voice view of the voice currently being scanned
    always_comb begin
        cur_active = 1'b0;
        cur_ptr    = '0;
`ifdef DRUM_VOICE_SCHED_GAIN_EN
        cur_gain   = 2'd0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (v_q == V_W'(i)) begin
                cur_active = active_q[i];
                cur_ptr    = ptr_q[i];
`ifdef DRUM_VOICE_SCHED_GAIN_EN
                cur_gain   = gain[2*i +: 2];
`endif
            end
        end
    end

`ifdef DRUM_VOICE_SCHED_GAIN_EN
    assign rd_scaled = $signed(mem_readdata) >>> cur_gain;
`else
    assign rd_scaled = $signed(mem_readdata);
`endif
    assign rd_ext = ACC_W'(rd_scaled);

    always_comb begin
        state_d        = state_q;
        v_d            = v_q;
        acc_d          = acc_q;
        ptr_d          = ptr_q;
        active_d       = active_q;
        pending_d      = pending_q | trig;
        addr_d         = addr_q;
        out_d          = out_q;
        valid_d        = 1'b0;
        overrun_d      = overrun_q | (sample_tick && (state_q != IDLE));
        mem_address    = addr_q;
        mem_chipselect = 1'b0;

        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    // Triggers arriving with the tick are folded into this scan
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (pending_q[i] || trig[i]) begin
                            ptr_d[i]    = '0;
                            active_d[i] = 1'b1;
                        end
                    end
                    pending_d = '0;
                    acc_d     = '0;
                    v_d       = '0;
                    state_d   = SEL;
                end
            end
            SEL: begin
                if (v_q == V_W'(NUM_VOICES)) begin
                    state_d = OUT;
                end else if (cur_active) begin
                    mem_address    = cur_ptr;
                    mem_chipselect = 1'b1;
                    addr_d         = cur_ptr;
                    state_d        = RD;
                end else begin
                    v_d = v_q + V_W'(1);
                end
            end
            RD: begin
                acc_d = acc_q + rd_ext;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (v_q == V_W'(i)) begin
                        if (ptr_q[i] == LAST_ADDR) begin
                            active_d[i] = 1'b0;
                            ptr_d[i]    = '0;
                        end else begin
                            ptr_d[i] = ptr_q[i] + ADDR_W'(1);
                        end
                    end
                end
                v_d     = v_q + V_W'(1);
                state_d = SEL;
            end
            OUT: begin
                out_d   = sat(acc_q);
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            v_q       <= '0;
            acc_q     <= '0;
            for (int i = 0; i < NUM_VOICES; i++) ptr_q[i] <= '0;
            active_q  <= '0;
            pending_q <= '0;
            addr_q    <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            acc_q     <= acc_d;
            ptr_q     <= ptr_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign mem_clken    = 1'b1;
    assign sample_out   = out_q;
    assign sample_valid = valid_q;
    assign voice_active = active_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_drum_voice_sched.sv
// Directed testbench for drum_voice_sched with a behavioural 1-cycle-latency sample RAM.
module tb_drum_voice_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [3:0]  trig = 4'b0;
    logic [12:0] mem_address;
    logic        mem_chipselect;
    logic        mem_clken;
    logic [15:0] mem_readdata;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic [3:0]  voice_active;
    logic        overrun;
`ifdef DRUM_VOICE_SCHED_GAIN_EN
    logic [7:0]  gain = 8'h00;
    localparam logic [15:0] GAIN_EXP = 16'h0100;
`else
    localparam logic [15:0] GAIN_EXP = 16'h0400;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [8192];
    logic [12:0] rd_log [$];

    drum_voice_sched dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .trig           (trig),
`ifdef DRUM_VOICE_SCHED_GAIN_EN
        .gain           (gain),
`endif
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .voice_active   (voice_active),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            mem_readdata <= mem[mem_address];
            rd_log.push_back(mem_address);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic init_ramp();
        for (int k = 0; k < 8192; k++) mem[k] = 16'(k);
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        trig = m;
        step();
        trig = 4'b0;
    endtask

    // Issue one tick and wait for its sample; lat = cycles from tick to valid, -1 on timeout
    task automatic do_tick(output int lat);
        rd_log.delete();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        lat = 1;
        while (!sample_valid && lat < 40) begin
            step();
            lat++;
        end
        if (!sample_valid) lat = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (sample_out !== 16'h0 || sample_valid !== 1'b0 || voice_active !== 4'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%h vld=%b act=%b ovr=%b, want 0000 0 0000 0",
                     sample_out, sample_valid, voice_active, overrun);
        end
        checks++;
        if (mem_chipselect !== 1'b0 || mem_address !== 13'h0 || mem_clken !== 1'b1) begin
            errors++;
            $display("FAIL reset_mem: got cs=%b addr=%h clken=%b, want 0 0000 1",
                     mem_chipselect, mem_address, mem_clken);
        end
    endtask

    task automatic test_idle_tick();
        int lat;
        do_reset();
        init_ramp();
        do_tick(lat);
        checks++;
        if (lat !== 7) begin
            errors++;
            $display("FAIL idle_latency: got %0d, want 7", lat);
        end
        checks++;
        if (sample_out !== 16'h0) begin
            errors++;
            $display("FAIL idle_sample: got %h, want 0000", sample_out);
        end
        checks++;
        if (rd_log.size() != 0) begin
            errors++;
            $display("FAIL idle_no_read: got %0d reads, want 0", rd_log.size());
        end
        step();
        checks++;
        if (sample_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid_pulse: got %b one cycle later, want 0", sample_valid);
        end
    endtask

    task automatic test_play();
        int lat;
        do_reset();
        init_ramp();
        pulse_trig(4'b0001);
        for (int t = 0; t < 3; t++) begin
            do_tick(lat);
            checks++;
            if (lat < 0 || sample_out !== 16'(t)) begin
                errors++;
                $display("FAIL play_sample%0d: got %h (lat %0d), want %h", t, sample_out, lat, 16'(t));
            end
            checks++;
            if (rd_log.size() != 1 || rd_log[0] !== 13'(t)) begin
                errors++;
                $display("FAIL play_addr%0d: got %0d reads first=%h, want 1 read at %h",
                         t, rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 13'h0, 13'(t));
            end
            checks++;
            if (voice_active !== 4'b0001) begin
                errors++;
                $display("FAIL play_active%0d: got %b, want 0001", t, voice_active);
            end
        end
    endtask

    task automatic test_saturation();
        int lat;
        do_reset();
        init_ramp();
        mem[0] = 16'h7000;
        pulse_trig(4'b0101);
        do_tick(lat);
        checks++;
        if (lat < 0 || sample_out !== 16'h7FFF) begin
            errors++;
            $display("FAIL sat_pos: got %h (lat %0d), want 7fff", sample_out, lat);
        end
        do_reset();
        mem[0] = 16'h9000;
        trig = 4'b0101;
        do_tick(lat);
        trig = 4'b0;
        checks++;
        if (lat < 0 || sample_out !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg: got %h (lat %0d), want 8000", sample_out, lat);
        end
        checks++;
        if (voice_active !== 4'b0101) begin
            errors++;
            $display("FAIL same_cycle_trig: got %b, want 0101", voice_active);
        end
    endtask

    task automatic test_end_of_sample();
        int lat;
        int timeouts = 0;
        do_reset();
        init_ramp();
        pulse_trig(4'b0010);
        for (int t = 0; t < 6777; t++) begin
            do_tick(lat);
            if (lat < 0) timeouts++;
        end
        checks++;
        if (timeouts != 0 || voice_active !== 4'b0010) begin
            errors++;
            $display("FAIL eos_before_last: got act=%b timeouts=%0d, want 0010 0", voice_active, timeouts);
        end
        do_tick(lat);
        checks++;
        if (lat < 0 || sample_out !== 16'd6777) begin
            errors++;
            $display("FAIL eos_last_sample: got %h, want %h", sample_out, 16'd6777);
        end
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 13'd6777 || voice_active !== 4'b0000) begin
            errors++;
            $display("FAIL eos_last_read: got %0d reads act=%b, want one read at 6777 act=0000",
                     rd_log.size(), voice_active);
        end
        do_tick(lat);
        checks++;
        if (lat < 0 || rd_log.size() != 0 || sample_out !== 16'h0) begin
            errors++;
            $display("FAIL eos_after: got %0d reads out=%h, want 0 reads out=0000", rd_log.size(), sample_out);
        end

        do_reset();
        mem[0] = 16'h0055;
        pulse_trig(4'b0010);
        for (int t = 0; t < 100; t++) do_tick(lat);
        pulse_trig(4'b0010);
        do_tick(lat);
        checks++;
        if (rd_log.size() != 1 || rd_log[0] !== 13'h0 || sample_out !== 16'h0055) begin
            errors++;
            $display("FAIL retrigger: got %0d reads first=%h out=%h, want one read at 0 out=0055",
                     rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 13'h0, sample_out);
        end
    endtask

    task automatic test_overrun();
        int nv = 0;
        do_reset();
        init_ramp();
        pulse_trig(4'b1111);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (sample_valid) nv++;
            step();
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, want 1", overrun);
        end
        checks++;
        if (nv != 1) begin
            errors++;
            $display("FAIL overrun_valids: got %0d, want 1", nv);
        end
        do_reset();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b, want 0", overrun);
        end

        nv = 0;
        pulse_trig(4'b1111);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        do_reset();
        for (int c = 0; c < 20; c++) begin
            if (sample_valid) nv++;
            step();
        end
        checks++;
        if (nv != 0 || voice_active !== 4'b0) begin
            errors++;
            $display("FAIL reset_abort: got %0d valids act=%b, want 0 0000", nv, voice_active);
        end
    endtask

    task automatic test_gain();
        int lat;
        do_reset();
        init_ramp();
        mem[0] = 16'h0400;
`ifdef DRUM_VOICE_SCHED_GAIN_EN
        gain = 8'h02;
`endif
        pulse_trig(4'b0001);
        do_tick(lat);
        checks++;
        if (lat < 0 || sample_out !== GAIN_EXP) begin
            errors++;
            $display("FAIL gain: got %h (lat %0d), want %h", sample_out, lat, GAIN_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_idle_tick();
        test_play();
        test_saturation();
        test_end_of_sample();
        test_overrun();
        test_gain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
